display_scan_ctrl: RTL and testbench

Scan controller for the multiplexed 8-position seven-segment clock display. Generates the digit-select sequence with a per-slot blanking window and presents the code for the active position. Holds a shadow copy of the six time digits, updated through a req/ack handshake at frame boundaries only, so a frame never shows a mix of old and new time. Sits between the time counters and the segment decoder; its `selct`/`num` outputs drive the decoder.

---
 rtl/display_pkg.sv | 28 ++
 rtl/display_scan_ctrl_if.sv | 26 ++
 rtl/display_shadow.sv | 38 +++
 rtl/display_scan_ctrl.sv | 155 +++++++++++++++
 tb/tb_display_scan_ctrl.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types and constants for the display scan controller
// Purpose: digit codes, scan FSM states, blink field selector, digit validity helper.
// Ports: none (package).
package display_pkg;

    localparam logic [3:0] DIGIT_DASH  = 4'd10;
    localparam logic [3:0] DIGIT_BLANK = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_SHOW  = 2'd2
    } scan_state_e;

    typedef enum logic [1:0] {
        BLINK_NONE = 2'd0,
        BLINK_HOUR = 2'd1,
        BLINK_MIN  = 2'd2,
        BLINK_SEC  = 2'd3
    } blink_field_e;

    // A shadow digit is shown only when it is a legal BCD value; bit 4 set
    // or a low nibble above 9 both turn the position dark.
    function automatic logic [3:0] digit_code(input logic [4:0] d);
        return (d[4] || (d[3:0] > 4'd9)) ? DIGIT_BLANK : d[3:0];
    endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// rtl/display_scan_ctrl_if.sv - time update bus between time counters and scan controller
// Purpose: carries the six BCD time digits and the upd_req/upd_ack handshake.
// Ports (modports): master = time counters (drive digits, upd_req; see upd_ack),
//                   slave  = scan controller (sees digits, upd_req; drives upd_ack).
interface display_scan_ctrl_if;

    logic [4:0] hour_a;
    logic [4:0] hour_b;
    logic [4:0] min_a;
    logic [4:0] min_b;
    logic [4:0] sec_a;
    logic [4:0] sec_b;
    logic       upd_req;
    logic       upd_ack;

    modport master (
        output hour_a, hour_b, min_a, min_b, sec_a, sec_b, upd_req,
        input  upd_ack
    );

    modport slave (
        input  hour_a, hour_b, min_a, min_b, sec_a, sec_b, upd_req,
        output upd_ack
    );

endinterface

// File: rtl/display_shadow.sv
// rtl/display_shadow.sv - shadow time digit registers with req/ack capture
// Purpose: holds the six digits shown by the scanner; loads them only when the
//          scanner signals a safe capture point.
// Ports: clk, rst (sync, active-high), cap_cond_i (capture allowed this edge),
//        upd_req_i, digits_i[0..5] (hour_a..sec_b), shadow_o[0..5], upd_ack_o.
module display_shadow (
    input  logic            clk,
    input  logic            rst,
    input  logic            cap_cond_i,
    input  logic            upd_req_i,
    input  logic [5:0][4:0] digits_i,
    output logic [5:0][4:0] shadow_o,
    output logic            upd_ack_o
);

    logic [5:0][4:0] shadow_q;
    logic            ack_q;
    logic            load;

    // ack_q blocks a second load while the requester is still dropping upd_req.
    assign load = upd_req_i && !ack_q && cap_cond_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            ack_q    <= 1'b0;
        end else begin
            ack_q <= load;
            if (load) begin
                shadow_q <= digits_i;
            end
        end
    end

    assign shadow_o  = shadow_q;
    assign upd_ack_o = ack_q;

endmodule

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - 8-position seven-segment scan controller
// Purpose: steps selct 0..7 with a blanking window at the start of each slot and
//          presents the code for the active position; time digits come from a
//          shadow copy refreshed only at frame boundaries.
// Ports: clk, rst (sync, active-high), en, blink_sel[1:0], upd (update bus, slave),
//        selct[3:0], num[3:0], blank, frame_start.
// Option: SCAN_BLINK_EN adds a frame counter that blinks the blink_sel field.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int DIV          = 1000,
    parameter int BLANK        = 50,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [1:0]          blink_sel,
    display_scan_ctrl_if.slave  upd,
    output logic [3:0]          selct,
    output logic [3:0]          num,
    output logic                blank,
    output logic                frame_start
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    scan_state_e       state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        pos_q;
    logic              blank_q;
    logic              fs_q;

    logic              slot_end;
    logic              frame_end;
    logic              cap_cond;
    logic [5:0][4:0]   shadow;
    logic [3:0]        code;
    blink_field_e      field;

    assign slot_end  = (state_q == S_SHOW) && (cnt_q == CNT_W'(DIV - 1));
    assign frame_end = slot_end && (pos_q == 3'd7);
    // While idle the shadow may follow requests freely; while scanning only the
    // 7->0 wrap is safe, so a frame never mixes old and new digits.
    assign cap_cond  = (state_q == S_IDLE) || frame_end;

    display_shadow u_shadow (
        .clk        (clk),
        .rst        (rst),
        .cap_cond_i (cap_cond),
        .upd_req_i  (upd.upd_req),
        .digits_i   ({upd.sec_b, upd.sec_a, upd.min_b, upd.min_a, upd.hour_b, upd.hour_a}),
        .shadow_o   (shadow),
        .upd_ack_o  (upd.upd_ack)
    );

`ifdef SCAN_BLINK_EN
    localparam int FR_W = (BLINK_FRAMES > 1) ? $clog2(2 * BLINK_FRAMES) : 1;
    logic [FR_W-1:0] frame_q;
    logic            blink_phase;
    assign blink_phase = (frame_q >= FR_W'(BLINK_FRAMES));
`endif

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pos_q   <= '0;
            blank_q <= 1'b1;
            fs_q    <= 1'b0;
`ifdef SCAN_BLINK_EN
            frame_q <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_BLANK;
                    cnt_q   <= '0;
                    pos_q   <= '0;
                    blank_q <= 1'b1;
                    fs_q    <= 1'b1;
`ifdef SCAN_BLINK_EN
                    frame_q <= '0;
`endif
                end
                S_BLANK: begin
                    fs_q  <= 1'b0;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(BLANK - 1)) begin
                        state_q <= S_SHOW;
                        blank_q <= 1'b0;
                    end
                end
                S_SHOW: begin
                    if (slot_end) begin
                        state_q <= S_BLANK;
                        cnt_q   <= '0;
                        blank_q <= 1'b1;
                        pos_q   <= pos_q + 1'b1;
                        fs_q    <= frame_end;
`ifdef SCAN_BLINK_EN
                        if (frame_end) begin
                            frame_q <= (frame_q == FR_W'(2 * BLINK_FRAMES - 1)) ? '0 : frame_q + 1'b1;
                        end
`endif
                    end else begin
                        fs_q  <= 1'b0;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    pos_q   <= '0;
                    blank_q <= 1'b1;
                    fs_q    <= 1'b0;
                end
            endcase
        end
    end

    // num is decoded from the registered position so it moves with selct.
    always_comb begin
        code  = DIGIT_BLANK;
        field = BLINK_NONE;
        case (pos_q)
            3'd0: begin code = digit_code(shadow[0]); field = BLINK_HOUR; end
            3'd1: begin code = digit_code(shadow[1]); field = BLINK_HOUR; end
            3'd3: begin code = digit_code(shadow[2]); field = BLINK_MIN;  end
            3'd4: begin code = digit_code(shadow[3]); field = BLINK_MIN;  end
            3'd6: begin code = digit_code(shadow[4]); field = BLINK_SEC;  end
            3'd7: begin code = digit_code(shadow[5]); field = BLINK_SEC;  end
            default: code = DIGIT_DASH;
        endcase
        if (state_q == S_IDLE) begin
            code = DIGIT_BLANK;
        end
`ifdef SCAN_BLINK_EN
        if (blink_phase && (field != BLINK_NONE) && (field == blink_field_e'(blink_sel))) begin
            code = DIGIT_BLANK;
        end
`endif
    end

`ifndef SCAN_BLINK_EN
    logic unused_blink;
    assign unused_blink = ^{blink_sel, field, 32'(BLINK_FRAMES)};
`endif

    assign selct       = {1'b0, pos_q};
    assign num         = code;
    assign blank       = blank_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - self-checking bench for display_scan_ctrl
module tb_display_scan_ctrl;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int BF    = 2;
    localparam int FRAME = 8 * DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] blink_sel;
    logic [3:0] selct;
    logic [3:0] num;
    logic       blank;
    logic       frame_start;

    display_scan_ctrl_if dif();

    display_scan_ctrl #(.DIV(DIV), .BLANK(BLANK), .BLINK_FRAMES(BF)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .blink_sel   (blink_sel),
        .upd         (dif),
        .selct       (selct),
        .num         (num),
        .blank       (blank),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    wire [10:0] obs = {selct, num, blank, frame_start, dif.upd_ack};

    int checks = 0;
    int passed = 0;

    // Reference: scanning is a plain cycle count m_t since enable.
    bit       m_active;
    int       m_t;
    bit       m_ack;
    int       m_sh[6];

    function automatic logic [10:0] expected();
        int pos, code, fld, d;
        bit bl;
        if (!m_active) return {4'd0, 4'd15, 1'b1, 1'b0, m_ack};
        pos = (m_t / DIV) % 8;
        if (pos == 2 || pos == 5) code = 10;
        else begin
            d = m_sh[pos < 2 ? pos : (pos < 5 ? pos - 1 : pos - 2)];
            code = (d > 9) ? 15 : d;
        end
`ifdef SCAN_BLINK_EN
        fld = (pos < 2) ? 1 : ((pos == 3 || pos == 4) ? 2 : ((pos >= 6) ? 3 : 0));
        if (fld != 0 && fld == int'(blink_sel) && ((m_t / FRAME) % (2 * BF)) >= BF) code = 15;
`else
        fld = 0;
`endif
        bl = (m_t % DIV) < BLANK;
        return {4'(pos), 4'(code), bl, ((m_t % FRAME) == 0), m_ack};
    endfunction

    task automatic set_digits(input int h1, h2, m1, m2, s1, s2);
        dif.hour_a = 5'(h1); dif.hour_b = 5'(h2);
        dif.min_a  = 5'(m1); dif.min_b  = 5'(m2);
        dif.sec_a  = 5'(s1); dif.sec_b  = 5'(s2);
    endtask

    // One clock edge: advance the reference with the inputs present at the edge,
    // then act as the requester (drop upd_req once acknowledged).
    task automatic tick();
        bit cap, ld;
        @(posedge clk);
        if (rst) begin
            m_active = 0; m_t = 0; m_ack = 0;
            foreach (m_sh[i]) m_sh[i] = 0;
        end else begin
            cap = !m_active || ((m_t % FRAME) == FRAME - 1);
            ld  = dif.upd_req && !m_ack && cap;
            if (ld) begin
                m_sh[0] = dif.hour_a; m_sh[1] = dif.hour_b;
                m_sh[2] = dif.min_a;  m_sh[3] = dif.min_b;
                m_sh[4] = dif.sec_a;  m_sh[5] = dif.sec_b;
            end
            m_ack = ld;
            if (!en) begin m_active = 0; m_t = 0; end
            else if (!m_active) begin m_active = 1; m_t = 0; end
            else m_t++;
        end
        #1;
        if (dif.upd_ack) dif.upd_req = 1'b0;
    endtask

    // Advance (unchecked) to the middle of the SHOW part of slot p.
    task automatic run_until_pos(input int p);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (m_active && ((m_t / DIV) % 8) == p && (m_t % DIV) == BLANK + 1) break;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1; en = 0; blink_sel = 0; dif.upd_req = 0;
        set_digits(0, 0, 0, 0, 0, 0);
        tick(); tick();
        checks++;
        if (obs !== {4'd0, 4'd15, 1'b1, 1'b0, 1'b0}) $display("FAIL reset_state got %h want %h", obs, {4'd0, 4'd15, 1'b1, 1'b0, 1'b0});
        else passed++;
        rst = 0;
    endtask

    task automatic test_scan();
        int fs_cnt = 0;
        en = 1;
        repeat (2 * FRAME) begin
            tick();
            if (frame_start) fs_cnt++;
            checks++;
            if (obs !== expected()) $display("FAIL scan t=%0t got %h want %h", $time, obs, expected());
            else passed++;
        end
        checks++;
        if (fs_cnt != 2) $display("FAIL scan_frame_start_count got %0d want 2", fs_cnt);
        else passed++;
    endtask

    task automatic test_update();
        int ack_cnt = 0, ack_t = 0;
        int seq[$];
        int want[8] = '{1, 2, 10, 3, 4, 10, 5, 6};
        run_until_pos(3);
        set_digits(1, 2, 3, 4, 5, 6);
        dif.upd_req = 1;
        repeat (2 * FRAME) begin
            tick();
            if (dif.upd_ack) begin ack_cnt++; ack_t = m_t; end
            if (ack_cnt == 1 && m_active && (m_t / FRAME) == (ack_t / FRAME) && (m_t % DIV) == BLANK)
                seq.push_back(int'(num));
            checks++;
            if (obs !== expected()) $display("FAIL update t=%0t got %h want %h", $time, obs, expected());
            else passed++;
        end
        checks++;
        if (ack_cnt != 1 || (ack_t % FRAME) != 0) $display("FAIL update_ack got count %0d at %0d want 1 at frame start", ack_cnt, ack_t % FRAME);
        else passed++;
        checks++;
        if (seq.size() != 8) $display("FAIL update_seq_len got %0d want 8", seq.size());
        else begin
            passed++;
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (seq[i] != want[i]) $display("FAIL update_seq[%0d] got %0d want %0d", i, seq[i], want[i]);
                else passed++;
            end
        end
    endtask

    task automatic test_en_drop();
        run_until_pos(5);
        en = 0;
        tick();
        checks++;
        if (obs !== {4'd0, 4'd15, 1'b1, 1'b0, 1'b0}) $display("FAIL en_drop got %h want %h", obs, {4'd0, 4'd15, 1'b1, 1'b0, 1'b0});
        else passed++;
        set_digits(2, 3, 19, 9, 1, 12);
        dif.upd_req = 1;
        tick();
        checks++;
        if (obs !== {4'd0, 4'd15, 1'b1, 1'b0, 1'b1}) $display("FAIL idle_capture_ack got %h want %h", obs, {4'd0, 4'd15, 1'b1, 1'b0, 1'b1});
        else passed++;
        checks++;
        if (obs !== expected()) $display("FAIL idle_capture_model got %h want %h", obs, expected());
        else passed++;
    endtask

    task automatic test_invalid_digit();
        en = 1;
        repeat (FRAME + 2) begin
            tick();
            checks++;
            if (obs !== expected()) $display("FAIL invalid t=%0t got %h want %h", $time, obs, expected());
            else passed++;
            if (m_active && (m_t % DIV) == BLANK) begin
                if (selct == 4'd7 || selct == 4'd3) begin
                    checks++;
                    if (num !== 4'd15) $display("FAIL invalid_pos%0d got %0d want 15", selct, num);
                    else passed++;
                end else if (selct == 4'd6) begin
                    checks++;
                    if (num !== 4'd1) $display("FAIL invalid_pos6 got %0d want 1", num);
                    else passed++;
                end
            end
        end
    endtask

    task automatic test_blink();
        logic [3:0] want;
        blink_sel = 2;
        en = 0; tick(); en = 1;
        repeat (8 * FRAME) begin
            tick();
            checks++;
            if (obs !== expected()) $display("FAIL blink t=%0t got %h want %h", $time, obs, expected());
            else passed++;
            if (m_active && (m_t % DIV) == BLANK && selct == 4'd4 && (m_t / FRAME) <= 3) begin
`ifdef SCAN_BLINK_EN
                want = ((m_t / FRAME) >= 2) ? 4'd15 : 4'd9;
`else
                want = 4'd9;
`endif
                checks++;
                if (num !== want) $display("FAIL blink_min_b frame %0d got %0d want %0d", m_t / FRAME, num, want);
                else passed++;
            end
        end
        blink_sel = 0;
        repeat (4 * FRAME) begin
            tick();
            checks++;
            if (obs !== expected()) $display("FAIL blink_none t=%0t got %h want %h", $time, obs, expected());
            else passed++;
        end
    endtask

    task automatic test_rst_mid();
        int acks = 0;
        run_until_pos(2);
        set_digits(7, 8, 1, 1, 2, 2);
        dif.upd_req = 1;
        tick();
        rst = 1;
        tick();
        checks++;
        if (obs !== {4'd0, 4'd15, 1'b1, 1'b0, 1'b0}) $display("FAIL rst_mid got %h want %h", obs, {4'd0, 4'd15, 1'b1, 1'b0, 1'b0});
        else passed++;
        rst = 0; dif.upd_req = 0;
        repeat (FRAME + 2) begin
            tick();
            if (dif.upd_ack) acks++;
            checks++;
            if (obs !== expected()) $display("FAIL rst_mid_frame t=%0t got %h want %h", $time, obs, expected());
            else passed++;
            if (m_active && (m_t % DIV) == BLANK && selct == 4'd0) begin
                checks++;
                if (num !== 4'd0) $display("FAIL rst_mid_shadow got %0d want 0", num);
                else passed++;
            end
        end
        checks++;
        if (acks != 0) $display("FAIL rst_mid_no_ack got %0d want 0", acks);
        else passed++;
    endtask

    task automatic test_random();
        repeat (1500) begin
            rst = ($urandom_range(0, 299) == 0);
            if (en) en = ($urandom_range(0, 199) != 0);
            else    en = ($urandom_range(0, 3) == 0);
            if (!dif.upd_req && $urandom_range(0, 39) == 0) begin
                set_digits($urandom_range(0, 11), $urandom_range(0, 11), $urandom_range(0, 11),
                           $urandom_range(0, 11), $urandom_range(0, 31), $urandom_range(0, 9));
                dif.upd_req = 1;
            end
            if ($urandom_range(0, 99) == 0) blink_sel = 2'($urandom_range(0, 3));
            tick();
            checks++;
            if (obs !== expected()) $display("FAIL random t=%0t got %h want %h", $time, obs, expected());
            else passed++;
        end
        rst = 0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_update();
        test_en_drop();
        test_invalid_digit();
        test_blink();
        test_rst_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
